pwm_sample_decoder: RTL and testbench

Receive-side counterpart of the chip's PWM audio output (`sigout`). The block samples a PWM waveform arriving on a GPIO pin, measures the high time of each PWM frame, and reconstructs the sample value that produced it. Each recovered sample comes out with a one-cycle valid strobe. It sits in the loopback/self-test path beside `top`: the FPGA or test harness feeds the chip's own output back in to check mixer output in hardware.

---
 rtl/pwm_sample_decoder_pkg.sv | 20 ++
 rtl/pwm_sample_decoder_sync_2ff.sv | 28 ++
 rtl/pwm_sample_decoder.sv | 189 ++++++++++++++++++
 tb/tb_pwm_sample_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sample_decoder_pkg.sv
// pwm_dec_pkg: shared types and defaults for the PWM sample decoder.
//   pwm_dec_state_t    : decoder FSM states (IDLE, MEASURE)
//   PWM_DEC_PERIOD_DEF : default PWM frame length in clk cycles
//   PWM_DEC_WIDTH_DEF  : default recovered sample width in bits
//   maj3()             : 3-input majority, used by the optional glitch filter
package pwm_dec_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_dec_state_t;

    localparam int unsigned PWM_DEC_PERIOD_DEF = 256;
    localparam int unsigned PWM_DEC_WIDTH_DEF  = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pwm_sample_decoder_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous level inputs
// (PWM loopback, pushbuttons). Both stages clear on reset.
//   clk  : destination clock
//   nrst : asynchronous active-low reset
//   d    : asynchronous input, WIDTH bits (each bit synchronized independently)
//   q    : synchronized output, two clk cycles behind d
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: recovers sample values from a looped-back PWM waveform.
// Each synchronized rising edge closes the running frame; a frame of exactly
// PERIOD cycles yields its high time as the sample, any other length yields a
// period_err pulse. A constant level for 2*PERIOD cycles yields full-scale or
// zero. All outputs are registered.
//
// Parameters:
//   PERIOD : nominal frame length in clk cycles (>= 4)
//   WIDTH  : sample width in bits
// Ports:
//   clk          : system clock
//   nrst         : asynchronous active-low reset
//   en           : decoder enable, low forces IDLE and clears the counters
//   pwm_in       : PWM input, asynchronous to clk
//   sample       : last recovered sample, held between updates
//   sample_valid : one-cycle pulse when sample updates
//   period_err   : one-cycle pulse when a frame length other than PERIOD is seen
//
// Build option: define PWM_DEC_GLITCH_FILTER_EN to insert a 3-tap majority
// filter after the synchronizer (rejects single-cycle glitches, adds 2 cycles
// of latency).
module pwm_sample_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PERIOD = PWM_DEC_PERIOD_DEF,
    parameter int unsigned WIDTH  = PWM_DEC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             period_err
);

    localparam int unsigned CW = $clog2(2 * PERIOD) + 1;

    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]    CNT_PERIOD  = CW'(PERIOD);
    localparam logic [CW-1:0]    CNT_TIMEOUT = CW'(2 * PERIOD);
    localparam logic [WIDTH-1:0] SAMPLE_MAX  = '1;

    pwm_dec_state_t state;
    pwm_dec_state_t state_next;

    logic             pwm_sync;
    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    hcnt;
    logic [CW-1:0]    hcnt_next;
    logic [WIDTH-1:0] sample_next;
    logic             valid_next;
    logic             err_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_sample(input logic [CW-1:0] v);
        if (32'(v) > 32'(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end
        return WIDTH'(v);
    endfunction

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (pwm_in),
        .q    (pwm_sync)
    );

`ifdef PWM_DEC_GLITCH_FILTER_EN
    // Two history taps plus the live synchronized bit form the 3-sample
    // majority window; the filtered level is registered.
    logic [1:0] taps;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            taps  <= '0;
            pwm_s <= 1'b0;
        end else begin
            taps  <= {taps[0], pwm_sync};
            pwm_s <= maj3(pwm_sync, taps[0], taps[1]);
        end
    end
`else
    always_comb begin
        pwm_s = pwm_sync;
    end
`endif

    assign rise = pwm_s & ~pwm_d;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = rise ? MEASURE : IDLE;
                MEASURE: state_next = MEASURE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output / datapath logic. cnt counts cycles since the frame anchor and
    // hcnt counts high cycles since the anchor, the anchor cycle included;
    // the anchor is either a rise or a timeout.
    always_comb begin
        cnt_next    = cnt;
        hcnt_next   = hcnt;
        sample_next = sample;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        if (!en) begin
            cnt_next  = '0;
            hcnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt_next  = CNT_ONE;
                        hcnt_next = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (cnt == CNT_PERIOD) begin
                            sample_next = clamp_sample(hcnt);
                            valid_next  = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                        cnt_next  = CNT_ONE;
                        hcnt_next = CNT_ONE;
                    end else if (cnt >= CNT_TIMEOUT) begin
                        sample_next = pwm_s ? SAMPLE_MAX : '0;
                        valid_next  = 1'b1;
                        cnt_next    = CNT_ONE;
                        hcnt_next   = CW'(pwm_s);
                    end else begin
                        cnt_next = sat_inc(cnt);
                        if (pwm_s) begin
                            hcnt_next = sat_inc(hcnt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pwm_d        <= 1'b0;
            cnt          <= '0;
            hcnt         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            period_err   <= 1'b0;
        end else begin
            pwm_d        <= pwm_s;
            cnt          <= cnt_next;
            hcnt         <= hcnt_next;
            sample       <= sample_next;
            sample_valid <= valid_next;
            period_err   <= err_next;
        end
    end

endmodule

// File: tb/tb_pwm_sample_decoder.sv
`timescale 1ns/1ps
module tb_pwm_sample_decoder;

    localparam int unsigned PERIOD = 256;
    localparam int unsigned WIDTH  = 8;
    localparam int          SMAX   = (1 << WIDTH) - 1;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam int LO_H = 2;
    localparam int HI_H = 254;
`else
    localparam int LAT  = 3;
    localparam int LO_H = 1;
    localparam int HI_H = 255;
`endif

    logic             clk    = 1'b0;
    logic             nrst   = 1'b0;
    logic             en     = 1'b1;
    logic             pwm_in = 1'b0;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             period_err;

    int checks = 0;
    int errors = 0;

    pwm_sample_decoder #(
        .PERIOD(PERIOD),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_err   (period_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on the history of pwm_in values seen at each active edge since
    // reset release. Frame rules: a synchronized rise closes the frame started
    // at the previous anchor; the decoded value is the number of high cycles
    // since that anchor; a frame of 2*PERIOD cycles without a rise times out.
    bit samp[$];
    bit ps_hist[$];
    bit armed;
    bit pd;
    int anchor;
    int exp_sample = 0;
    bit exp_valid  = 1'b0;
    bit exp_err    = 1'b0;

    function automatic bit level_at(input int k);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        int ones = 0;
        for (int d = 3; d <= 5; d++) begin
            if (k - d >= 0 && samp[k - d]) ones++;
        end
        return ones >= 2;
`else
        return (k >= 2) ? samp[k - 2] : 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            samp.delete();
            ps_hist.delete();
            armed      = 1'b0;
            pd         = 1'b0;
            anchor     = 0;
            exp_sample = 0;
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
        end else begin
            int  k;
            int  h;
            bit  ps;
            bit  rse;
            k = samp.size();
            samp.push_back(pwm_in);
            ps  = level_at(k);
            rse = ps && !pd;
            ps_hist.push_back(ps);
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (!en) begin
                armed = 1'b0;
            end else if (!armed) begin
                if (rse) begin
                    armed  = 1'b1;
                    anchor = k;
                end
            end else if (rse) begin
                if (k - anchor == int'(PERIOD)) begin
                    h = 0;
                    for (int j = anchor; j < k; j++) h += int'(ps_hist[j]);
                    exp_sample = (h > SMAX) ? SMAX : h;
                    exp_valid  = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                anchor = k;
            end else if (k - anchor == 2 * int'(PERIOD)) begin
                exp_sample = ps ? SMAX : 0;
                exp_valid  = 1'b1;
                anchor     = k;
            end
            pd = ps;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("sample", 32'(sample), exp_sample);
        check("sample_valid", 32'(sample_valid), int'(exp_valid));
        check("period_err", 32'(period_err), int'(exp_err));
        check("pulse_exclusive", 32'(sample_valid & period_err), 0);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame: high for the first 'high' cycles, optional single-cycle
    // inversion at 'glitch', optional en drop at 'en_drop' (en is raised at the
    // frame start). Reports first/last pulse step (1-based, -1 if none) and counts.
    task automatic drive_frame(input int len, input int high, input int glitch, input int en_drop,
                               output int lat, output int last, output int nv, output int ne);
        lat  = -1;
        last = -1;
        nv   = 0;
        ne   = 0;
        en   = 1'b1;
        for (int i = 0; i < len; i++) begin
            pwm_in = (i < high) ^ (i == glitch);
            if (i == en_drop) en = 1'b0;
            step();
            if (sample_valid) begin
                nv++;
                if (lat < 0) lat = i + 1;
                last = i + 1;
            end
            if (period_err) ne++;
        end
    endtask

    initial begin
        int lat, last, nv, ne, tot_err;

        // Reset state
        nrst = 1'b0;
        repeat (3) step();
        check("rst_sample", 32'(sample), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_err", 32'(period_err), 0);
        nrst = 1'b1;
        repeat (5) step();

        // Steady duty
        for (int f = 0; f < 4; f++) begin
            drive_frame(256, 100, -1, -1, lat, last, nv, ne);
            if (f == 0) check("steady_first_nv", 32'(nv), 0);
            else check("steady_lat", 32'(lat), LAT);
            check("steady_err", 32'(ne), 0);
        end
        check("steady_sample", 32'(sample), 100);

        // Extreme duty
        tot_err = 0;
        for (int f = 0; f < 3; f++) begin
            drive_frame(256, LO_H, -1, -1, lat, last, nv, ne);
            tot_err += ne;
        end
        check("lo_sample", 32'(sample), LO_H);
        for (int f = 0; f < 3; f++) begin
            drive_frame(256, HI_H, -1, -1, lat, last, nv, ne);
            tot_err += ne;
        end
        check("hi_sample", 32'(sample), HI_H);
        check("extreme_err", 32'(tot_err), 0);

        // Bad period
        drive_frame(200, 100, -1, -1, lat, last, nv, ne);
        check("bad_pre_nv", 32'(nv), 1);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("bad_err", 32'(ne), 1);
        check("bad_nv", 32'(nv), 0);
        check("bad_hold", 32'(sample), HI_H);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("bad_recover_lat", 32'(lat), LAT);
        check("bad_recover_sample", 32'(sample), 100);

        // Constant level
        drive_frame(600, 600, -1, -1, lat, last, nv, ne);
        check("const_hi_nv", 32'(nv), 2);
        check("const_hi_timeout", 32'(last), LAT + 2 * int'(PERIOD));
        check("const_hi_sample", 32'(sample), SMAX);
        drive_frame(600, 0, -1, -1, lat, last, nv, ne);
        check("const_lo_nv", 32'(nv), 1);
        check("const_lo_sample", 32'(sample), 0);

        // Enable dropped mid-frame
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        drive_frame(256, 100, -1, 50, lat, last, nv, ne);
        check("en_mid_nv", 32'(nv), 1);
        check("en_mid_last", 32'(last), LAT);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("en_rearm_nv", 32'(nv), 0);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("en_after_lat", 32'(lat), LAT);

        // Rise coinciding with en falling
        drive_frame(256, 100, -1, LAT - 1, lat, last, nv, ne);
        check("en_rise_nv", 32'(nv + ne), 0);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("en_rise_rearm_nv", 32'(nv), 0);

        // Reset mid-frame
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("pre_rst_sample", 32'(sample), 100);
        pwm_in = 1'b1;
        repeat (30) step();
        nrst = 1'b0;
        #1;
        check("rst_mid_sample", 32'(sample), 0);
        check("rst_mid_valid", 32'(sample_valid), 0);
        repeat (3) step();
        pwm_in = 1'b0;
        nrst   = 1'b1;
        repeat (4) step();
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("rst_rearm_nv", 32'(nv), 0);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("rst_after_lat", 32'(lat), LAT);

`ifdef PWM_DEC_GLITCH_FILTER_EN
        // Single-cycle low glitch inside a 100-high frame
        drive_frame(256, 100, 50, -1, lat, last, nv, ne);
        drive_frame(256, 100, -1, -1, lat, last, nv, ne);
        check("glitch_lat", 32'(lat), 5);
        check("glitch_err", 32'(ne), 0);
        check("glitch_sample", 32'(sample), 100);
`endif

        // Randomized frames, checked by the model every cycle
        for (int f = 0; f < 30; f++) begin
            int len, high, g, ed;
            len  = ($urandom % 6 == 0) ? int'($urandom_range(200, 300)) : 256;
            if ($urandom % 10 == 0) len = 700;
            high = int'($urandom_range(0, len));
            g    = ($urandom % 4 == 0) ? int'($urandom_range(0, len - 1)) : -1;
            ed   = ($urandom % 10 == 0) ? int'($urandom_range(0, len - 1)) : -1;
            drive_frame(len, high, g, ed, lat, last, nv, ne);
        end
        en     = 1'b1;
        pwm_in = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
